// File: rtl/shift_reg_elastic_pkg.sv
// Shared helpers for the elastic delay pipeline.
package shift_reg_elastic_pkg;

  // Occupancy counter width: enough bits for 0..depth, never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_reg_elastic_if.sv
// Upstream/downstream handshake bundle of the elastic delay pipeline.
interface shift_reg_elastic_if #(
  parameter int Depth = 4,
  parameter int Width = 32
);
  import shift_reg_elastic_pkg::*;

  localparam int CntW = cnt_width(Depth);

  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [Width-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic [Width-1:0] data_o;
  logic [CntW-1:0]  occupancy_o;
  logic             empty_o;

  modport slave (
    input  flush_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, occupancy_o, empty_o
  );

  modport master (
    output flush_i, valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, occupancy_o, empty_o
  );

endinterface

// File: rtl/gnrl_dff.sv
// Generic reset flops: plain and load-enabled, async active-low reset to zero.
module gnrl_dffr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qout <= '0;
    else        qout <= dnxt;
  end
endmodule

module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    qout <= '0;
    else if (lden) qout <= dnxt;
  end
endmodule

// File: rtl/shift_reg_elastic_stage.sv
// One pipeline stage: valid bit advances on en, payload loads only for a real beat.
module shift_reg_elastic_stage #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush,
  input  logic             en,
  input  logic             valid_d,
  input  logic [Width-1:0] data_d,
  output logic             valid_q,
  output logic [Width-1:0] data_q
);
  logic valid_nxt;

  assign valid_nxt = ~flush & (en ? valid_d : valid_q);

  gnrl_dffr #(.DW(1)) u_valid (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .dnxt  (valid_nxt),
    .qout  (valid_q)
  );

  // Payload is left untouched by bubbles and flushes so the flop bank can be clock-gated.
  gnrl_dfflr #(.DW(Width)) u_data (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .lden  (en & valid_d & ~flush),
    .dnxt  (data_d),
    .qout  (data_q)
  );
endmodule

// File: rtl/shift_reg_elastic.sv
// Fixed-depth delay pipeline with valid/ready backpressure, bubble collapsing,
// synchronous flush and occupancy count.
module shift_reg_elastic
  import shift_reg_elastic_pkg::*;
#(
  parameter int Depth = 4,
  parameter int Width = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  shift_reg_elastic_if.slave   pipe
);
  localparam int CntW = cnt_width(Depth);

  if (Depth == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass    = ^{clk_i, rst_ni, pipe.flush_i};
    assign pipe.valid_o     = pipe.valid_i;
    assign pipe.ready_o     = pipe.ready_i;
    assign pipe.data_o      = pipe.data_i;
    assign pipe.occupancy_o = '0;
    assign pipe.empty_o     = 1'b1;
  end else begin : g_pipe
    logic [Depth:0]   en;
    logic [Depth-1:0] valid_q;
    logic [Depth-1:0] valid_d;
    logic [Width-1:0] data_q [Depth];
    logic [Width-1:0] data_d [Depth];
    logic [CntW-1:0]  count;
    logic [CntW-1:0]  count_nxt;
    logic             acc;
    logic             ret;

    // A stage may advance when it is empty or everything downstream of it advances.
    always_comb begin
      en        = '0;
      en[Depth] = pipe.ready_i;
      for (int k = Depth - 1; k >= 0; k--) begin
        en[k] = ~valid_q[k] | en[k+1];
      end
    end

    for (genvar k = 0; k < Depth; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign valid_d[k] = pipe.valid_i & ~pipe.flush_i;
        assign data_d[k]  = pipe.data_i;
      end else begin : g_body
        assign valid_d[k] = valid_q[k-1];
        assign data_d[k]  = data_q[k-1];
      end

      shift_reg_elastic_stage #(.Width(Width)) u_stage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush   (pipe.flush_i),
        .en      (en[k]),
        .valid_d (valid_d[k]),
        .data_d  (data_d[k]),
        .valid_q (valid_q[k]),
        .data_q  (data_q[k])
      );
    end

    assign pipe.ready_o = en[0] & ~pipe.flush_i;
    assign pipe.valid_o = valid_q[Depth-1] & ~pipe.flush_i;
    assign pipe.data_o  = data_q[Depth-1];

    assign acc = pipe.valid_i & pipe.ready_o;
    assign ret = pipe.valid_o & pipe.ready_i;

    always_comb begin
      count_nxt = count;
      if (pipe.flush_i) begin
        count_nxt = '0;
      end else begin
        case ({acc, ret})
          2'b10:   count_nxt = count + CntW'(1);
          2'b01:   count_nxt = count - CntW'(1);
          default: count_nxt = count;
        endcase
      end
    end

    gnrl_dffr #(.DW(CntW)) u_count (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .dnxt  (count_nxt),
      .qout  (count)
    );

    assign pipe.occupancy_o = count;
    assign pipe.empty_o     = (count == '0);

    ap_count_matches: assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(count) == $countones(valid_q));
    ap_no_ready_in_flush: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pipe.ready_o && pipe.flush_i));
    ap_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(count) <= Depth);
  end
endmodule

// File: tb/tb_shift_reg_elastic.sv
// Directed vectors for Depth=4, pass-through checks for Depth=0, and a random-stall
// scoreboard for Depth=1 and Depth=7.
module tb_shift_reg_elastic;

  typedef struct {
    int         tid;
    logic       fl, vi, ri;
    logic [7:0] di;
    logic       e_rdy, e_vo;
    logic [7:0] e_do;
    int         e_occ;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  shift_reg_elastic_if #(.Depth(4), .Width(8)) if4 ();
  shift_reg_elastic_if #(.Depth(0), .Width(8)) if0 ();
  shift_reg_elastic_if #(.Depth(1), .Width(8)) if1 ();
  shift_reg_elastic_if #(.Depth(7), .Width(8)) if7 ();

  shift_reg_elastic #(.Depth(4), .Width(8)) u4 (.clk_i(clk), .rst_ni(rst_n), .pipe(if4));
  shift_reg_elastic #(.Depth(0), .Width(8)) u0 (.clk_i(clk), .rst_ni(rst_n), .pipe(if0));
  shift_reg_elastic #(.Depth(1), .Width(8)) u1 (.clk_i(clk), .rst_ni(rst_n), .pipe(if1));
  shift_reg_elastic #(.Depth(7), .Width(8)) u7 (.clk_i(clk), .rst_ni(rst_n), .pipe(if7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Producer protocol: a stalled beat stays valid with stable data.
  ap_hold4: assert property (@(posedge clk) disable iff (!rst_n)
    (if4.valid_i && !if4.ready_o && !if4.flush_i) |=> (if4.valid_i && $stable(if4.data_i)));
  ap_hold1: assert property (@(posedge clk) disable iff (!rst_n)
    (if1.valid_i && !if1.ready_o) |=> (if1.valid_i && $stable(if1.data_i)));
  ap_hold7: assert property (@(posedge clk) disable iff (!rst_n)
    (if7.valid_i && !if7.ready_o) |=> (if7.valid_i && $stable(if7.data_i)));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int tid, input int fl, input int vi, input int ri, input int di,
                              input int e_rdy, input int e_vo, input int e_do, input int e_occ);
    vec_t v;
    v.tid   = tid;
    v.fl    = (fl != 0);
    v.vi    = (vi != 0);
    v.ri    = (ri != 0);
    v.di    = 8'(di);
    v.e_rdy = (e_rdy != 0);
    v.e_vo  = (e_vo != 0);
    v.e_do  = 8'(e_do);
    v.e_occ = e_occ;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("t%0d_v%0d", v.tid, idx);
    @(negedge clk);
    if4.flush_i = v.fl;
    if4.valid_i = v.vi;
    if4.ready_i = v.ri;
    if4.data_i  = v.di;
    #2;
    chk({tag, ".ready_o"},     32'(if4.ready_o),     32'(v.e_rdy));
    chk({tag, ".valid_o"},     32'(if4.valid_o),     32'(v.e_vo));
    chk({tag, ".occupancy_o"}, 32'(if4.occupancy_o), 32'(v.e_occ));
    chk({tag, ".empty_o"},     32'(if4.empty_o),     32'(v.e_occ == 0));
    if (v.e_vo) chk({tag, ".data_o"}, 32'(if4.data_o), 32'(v.e_do));
  endtask

  // Scoreboard state, index 0 = Depth 1 instance, index 1 = Depth 7 instance.
  logic       sb_vi   [2];
  logic       sb_ri   [2];
  logic       sb_hold [2];
  logic [7:0] sb_di   [2];
  logic [7:0] sb_nxt  [2];
  logic [7:0] sb_mem  [2][16];
  int         sb_t    [2][16];
  int         sb_head [2];
  int         sb_cnt  [2];

  task automatic sb_step(input int id, input int depth, input logic vo, input logic rdy,
                         input logic [7:0] dout, input int occ, input logic emp, input int cyc);
    string tag;
    tag = $sformatf("sb_d%0d_c%0d", depth, cyc);
    chk({tag, ".ready_o"},     32'(rdy), 32'((sb_cnt[id] < depth) || sb_ri[id]));
    chk({tag, ".occupancy_o"}, 32'(occ), 32'(sb_cnt[id]));
    chk({tag, ".empty_o"},     32'(emp), 32'(sb_cnt[id] == 0));
    if (vo) begin
      chk({tag, ".nonempty"}, 32'(sb_cnt[id] > 0), 32'(1));
      chk({tag, ".data_o"},   32'(dout), 32'(sb_mem[id][sb_head[id]]));
      chk({tag, ".latency_ok"}, 32'((cyc - sb_t[id][sb_head[id]]) >= depth), 32'(1));
    end
    if (sb_vi[id] && rdy) begin
      sb_mem[id][(sb_head[id] + sb_cnt[id]) % 16] = sb_di[id];
      sb_t[id][(sb_head[id] + sb_cnt[id]) % 16]   = cyc;
      sb_cnt[id]++;
    end
    if (vo && sb_ri[id]) begin
      sb_head[id] = (sb_head[id] + 1) % 16;
      sb_cnt[id]--;
    end
    sb_hold[id] = sb_vi[id] && !rdy;
  endtask

  vec_t tbl[$];
  vec_t t5a[$];
  vec_t t5b[$];

  initial begin
    // Test 1: back-to-back stream, 4-cycle latency, then drain.
    for (int i = 0; i < 21; i++) begin
      tbl.push_back(mk(1, 0, int'(i < 16), 1, (i < 16) ? i + 1 : 0,
                       1, int'(i >= 4 && i < 20), i - 3,
                       ((i < 16) ? i : 16) - ((i > 4) ? (((i < 20) ? i : 20) - 4) : 0)));
    end
    // Test 2: fill under stall, pass-through ready on release.
    tbl.push_back(mk(2, 0, 1, 0, 'hA0, 1, 0, 0,     0));
    tbl.push_back(mk(2, 0, 1, 0, 'hA1, 1, 0, 0,     1));
    tbl.push_back(mk(2, 0, 1, 0, 'hA2, 1, 0, 0,     2));
    tbl.push_back(mk(2, 0, 1, 0, 'hA3, 1, 0, 0,     3));
    tbl.push_back(mk(2, 0, 1, 0, 'hA4, 0, 1, 'hA0,  4));
    tbl.push_back(mk(2, 0, 1, 0, 'hA4, 0, 1, 'hA0,  4));
    tbl.push_back(mk(2, 0, 1, 1, 'hA4, 1, 1, 'hA0,  4));
    tbl.push_back(mk(2, 0, 0, 1, 0,    1, 1, 'hA1,  4));
    tbl.push_back(mk(2, 0, 0, 1, 0,    1, 1, 'hA2,  3));
    tbl.push_back(mk(2, 0, 0, 1, 0,    1, 1, 'hA3,  2));
    tbl.push_back(mk(2, 0, 0, 1, 0,    1, 1, 'hA4,  1));
    tbl.push_back(mk(2, 0, 0, 1, 0,    1, 0, 0,     0));
    // Test 3: bubble compaction under stall.
    tbl.push_back(mk(3, 0, 1, 0, 'h11, 1, 0, 0,     0));
    tbl.push_back(mk(3, 0, 0, 0, 0,    1, 0, 0,     1));
    tbl.push_back(mk(3, 0, 1, 0, 'h22, 1, 0, 0,     1));
    tbl.push_back(mk(3, 0, 0, 0, 0,    1, 0, 0,     2));
    tbl.push_back(mk(3, 0, 0, 0, 0,    1, 1, 'h11,  2));
    tbl.push_back(mk(3, 0, 0, 0, 0,    1, 1, 'h11,  2));
    tbl.push_back(mk(3, 0, 0, 1, 0,    1, 1, 'h11,  2));
    tbl.push_back(mk(3, 0, 0, 1, 0,    1, 1, 'h22,  1));
    tbl.push_back(mk(3, 0, 0, 1, 0,    1, 0, 0,     0));
    // Test 4: flush with 3 beats held, then normal operation and a held flush.
    tbl.push_back(mk(4, 0, 1, 0, 'h31, 1, 0, 0,     0));
    tbl.push_back(mk(4, 0, 1, 0, 'h32, 1, 0, 0,     1));
    tbl.push_back(mk(4, 0, 1, 0, 'h33, 1, 0, 0,     2));
    tbl.push_back(mk(4, 0, 0, 0, 0,    1, 0, 0,     3));
    tbl.push_back(mk(4, 1, 1, 1, 'h34, 0, 0, 0,     3));
    tbl.push_back(mk(4, 0, 1, 1, 'h35, 1, 0, 0,     0));
    tbl.push_back(mk(4, 0, 0, 1, 0,    1, 0, 0,     1));
    tbl.push_back(mk(4, 0, 0, 1, 0,    1, 0, 0,     1));
    tbl.push_back(mk(4, 0, 0, 1, 0,    1, 0, 0,     1));
    tbl.push_back(mk(4, 0, 0, 1, 0,    1, 1, 'h35,  1));
    tbl.push_back(mk(4, 0, 0, 1, 0,    1, 0, 0,     0));
    tbl.push_back(mk(4, 1, 1, 1, 'h36, 0, 0, 0,     0));
    tbl.push_back(mk(4, 1, 1, 1, 'h36, 0, 0, 0,     0));
    tbl.push_back(mk(4, 0, 0, 1, 0,    1, 0, 0,     0));
    // Test 5: two beats in flight before an async reset, then a clean stream.
    t5a.push_back(mk(5, 0, 1, 0, 'h51, 1, 0, 0,     0));
    t5a.push_back(mk(5, 0, 1, 0, 'h52, 1, 0, 0,     1));
    t5a.push_back(mk(5, 0, 0, 0, 0,    1, 0, 0,     2));
    t5a.push_back(mk(5, 0, 0, 0, 0,    1, 0, 0,     2));
    t5a.push_back(mk(5, 0, 0, 0, 0,    1, 1, 'h51,  2));
    t5b.push_back(mk(5, 0, 1, 1, 'h61, 1, 0, 0,     0));
    t5b.push_back(mk(5, 0, 1, 1, 'h62, 1, 0, 0,     1));
    t5b.push_back(mk(5, 0, 0, 1, 0,    1, 0, 0,     2));
    t5b.push_back(mk(5, 0, 0, 1, 0,    1, 0, 0,     2));
    t5b.push_back(mk(5, 0, 0, 1, 0,    1, 1, 'h61,  2));
    t5b.push_back(mk(5, 0, 0, 1, 0,    1, 1, 'h62,  1));
    t5b.push_back(mk(5, 0, 0, 1, 0,    1, 0, 0,     0));

    rst_n = 1'b0;
    if4.flush_i = 1'b0; if4.valid_i = 1'b0; if4.ready_i = 1'b0; if4.data_i = 8'h00;
    if0.flush_i = 1'b0; if0.valid_i = 1'b0; if0.ready_i = 1'b0; if0.data_i = 8'h00;
    if1.flush_i = 1'b0; if1.valid_i = 1'b0; if1.ready_i = 1'b0; if1.data_i = 8'h00;
    if7.flush_i = 1'b0; if7.valid_i = 1'b0; if7.ready_i = 1'b0; if7.data_i = 8'h00;
    #1;
    chk("reset.valid_o",     32'(if4.valid_o),     32'(0));
    chk("reset.data_o",      32'(if4.data_o),      32'(0));
    chk("reset.occupancy_o", 32'(if4.occupancy_o), 32'(0));
    chk("reset.empty_o",     32'(if4.empty_o),     32'(1));
    chk("reset.ready_o",     32'(if4.ready_o),     32'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);
    foreach (t5a[i]) apply(t5a[i], i);

    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst.valid_o",     32'(if4.valid_o),     32'(0));
    chk("t5_rst.occupancy_o", 32'(if4.occupancy_o), 32'(0));
    chk("t5_rst.empty_o",     32'(if4.empty_o),     32'(1));
    chk("t5_rst.data_o",      32'(if4.data_o),      32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    foreach (t5b[i]) apply(t5b[i], 100 + i);

    // Test 6a: Depth 0 is a pure wire.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if0.flush_i = 1'($urandom_range(0, 1));
      if0.valid_i = 1'($urandom_range(0, 1));
      if0.ready_i = 1'($urandom_range(0, 1));
      if0.data_i  = 8'($urandom_range(0, 255));
      #2;
      chk($sformatf("d0_c%0d.valid_o", i), 32'(if0.valid_o),     32'(if0.valid_i));
      chk($sformatf("d0_c%0d.ready_o", i), 32'(if0.ready_o),     32'(if0.ready_i));
      chk($sformatf("d0_c%0d.data_o", i),  32'(if0.data_o),      32'(if0.data_i));
      chk($sformatf("d0_c%0d.occ", i),     32'(if0.occupancy_o), 32'(0));
      chk($sformatf("d0_c%0d.empty", i),   32'(if0.empty_o),     32'(1));
    end

    // Test 6b: random stalls on Depth 1 and Depth 7 against an in-order queue model.
    for (int id = 0; id < 2; id++) begin
      sb_hold[id] = 1'b0; sb_vi[id] = 1'b0; sb_ri[id] = 1'b0;
      sb_di[id] = 8'h00; sb_nxt[id] = 8'(8'h40 * (id + 1));
      sb_head[id] = 0; sb_cnt[id] = 0;
    end
    for (int cyc = 0; cyc < 360; cyc++) begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        if (!sb_hold[id]) begin
          sb_vi[id] = (cyc < 320) && ($urandom_range(0, 2) != 0);
          sb_di[id] = sb_nxt[id];
          if (sb_vi[id]) sb_nxt[id] = sb_nxt[id] + 8'd1;
        end
        sb_ri[id] = (cyc >= 320) || ($urandom_range(0, 2) != 0);
      end
      if1.valid_i = sb_vi[0]; if1.data_i = sb_di[0]; if1.ready_i = sb_ri[0];
      if7.valid_i = sb_vi[1]; if7.data_i = sb_di[1]; if7.ready_i = sb_ri[1];
      #2;
      sb_step(0, 1, if1.valid_o, if1.ready_o, if1.data_o, int'(if1.occupancy_o), if1.empty_o, cyc);
      sb_step(1, 7, if7.valid_o, if7.ready_o, if7.data_o, int'(if7.occupancy_o), if7.empty_o, cyc);
    end
    chk("sb_d1.drained", 32'(sb_cnt[0]), 32'(0));
    chk("sb_d7.drained", 32'(sb_cnt[1]), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
